// File: rtl/lc3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lc3_pkg                                                           |
// | Shared LC-3 operate-path definitions: opcodes, ALU function codes,         |
// | sequencer state encoding and the operate-instruction decoder.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package lc3_pkg;

  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0101;
  localparam logic [3:0] OPC_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOT  = 2'b11
  } alu_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic    legal;
    alu_fn_e fn;
  } op_dec_t;

  // Maps an opcode to its ALU function. NOT is only legal with an all-ones
  // low field when the strict check is enabled.
  function automatic op_dec_t decode_op(input logic [3:0] opc,
                                        input logic [5:0] low6,
                                        input logic       strict_not);
    op_dec_t d;
    d.legal = 1'b1;
    d.fn    = ALU_PASS;
    case (opc)
      OPC_ADD: d.fn = ALU_ADD;
      OPC_AND: d.fn = ALU_AND;
      OPC_NOT: begin
        d.fn    = ALU_NOT;
        d.legal = !strict_not || (low6 == 6'b111111);
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_alu_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lc3_alu_sequencer_if                                              |
// | Bundles the instruction handshake, register-file and ALU signals of the    |
// | operate sequencer.                                                         |
// |   master : sequencer side (drives strobes, addresses, ALU operands)        |
// |   slave  : environment side (instruction source, register file, ALU)       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface lc3_alu_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic              rf_rd_en;
  logic [2:0]        rf_sr1;
  logic [2:0]        rf_sr2;
  logic [DATA_W-1:0] rf_ra;
  logic [DATA_W-1:0] rf_rb;
  logic [DATA_W-1:0] alu_ra;
  logic [DATA_W-1:0] alu_rb;
  logic [5:0]        alu_ir;
  logic [1:0]        alu_control;
  logic [DATA_W-1:0] alu_out;
  logic              rf_wr_en;
  logic [2:0]        rf_dr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [2:0]        nzp;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_ra, rf_rb, alu_out,
    output instr_ready, rf_rd_en, rf_sr1, rf_sr2, alu_ra, alu_rb, alu_ir,
           alu_control, rf_wr_en, rf_dr, rf_wr_data, nzp, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_ra, rf_rb, alu_out,
    input  instr_ready, rf_rd_en, rf_sr1, rf_sr2, alu_ra, alu_rb, alu_ir,
           alu_control, rf_wr_en, rf_dr, rf_wr_data, nzp, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/lc3_cc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lc3_cc_reg                                                        |
// | LC-3 condition-code register. On load, sets exactly one of {N,Z,P} from    |
// | the sign/zero status of the data word.                                     |
// |   clk, reset_n : clock, asynchronous active-low reset (resets to Z)        |
// |   load         : capture condition codes from data                         |
// |   data         : value whose sign/zero status is recorded                  |
// |   nzp          : registered {N,Z,P}                                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lc3_cc_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic [2:0]        nzp
);

  logic [2:0] nzp_q;
  logic [2:0] nzp_d;

  always_comb begin
    nzp_d = nzp_q;
    if (load) begin
      if (data[DATA_W-1]) begin
        nzp_d = 3'b100;
      end else if (data == '0) begin
        nzp_d = 3'b010;
      end else begin
        nzp_d = 3'b001;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzp_q <= 3'b010;
    end else begin
      nzp_q <= nzp_d;
    end
  end

  assign nzp = nzp_q;

endmodule
`default_nettype wire

// File: rtl/lc3_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lc3_alu_sequencer                                                 |
// | Multi-cycle sequencer for LC-3 ADD/AND/NOT: accepts an instruction, reads  |
// | the register file, presents operands and function code to the ALU, then    |
// | writes the result back and updates NZP. IDLE -> READ -> EXEC -> WRITE.     |
// |   clk, reset_n : clock, asynchronous active-low reset                      |
// |   bus          : master side of lc3_alu_sequencer_if (handshake, register  |
// |                  file read/write, ALU operands/result, nzp, done, illegal) |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lc3_alu_sequencer #(
  parameter int DATA_W     = 16,
  parameter bit STRICT_NOT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  lc3_alu_sequencer_if.master   bus
);
  import lc3_pkg::*;

  seq_state_e        state_q, state_d;
  logic [11:0]       ir_q, ir_d;      // opcode field is consumed at accept
  alu_fn_e           fn_q, fn_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              illegal_q, illegal_d;

  op_dec_t           dec;
  logic              in_write;

  assign dec      = decode_op(bus.instr[15:12], bus.instr[5:0], STRICT_NOT);
  assign in_write = (state_q == ST_WRITE);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    fn_d      = fn_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          // Illegal words are consumed but never latched, so the register
          // addresses and ALU immediate keep showing the last legal op.
          if (dec.legal) begin
            ir_d    = bus.instr[11:0];
            fn_d    = dec.fn;
            state_d = ST_READ;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC: begin
        // Register-file data arrives one cycle after the read strobe.
        op_a_d  = bus.rf_ra;
        op_b_d  = bus.rf_rb;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      fn_q      <= ALU_PASS;
      op_a_q    <= '0;
      op_b_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      fn_q      <= fn_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decode from the state register only.
  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.rf_rd_en    = (state_q == ST_READ);
  assign bus.rf_wr_en    = in_write;
  assign bus.done        = in_write;
  assign bus.illegal     = illegal_q;

  assign bus.rf_sr1      = ir_q[8:6];
  assign bus.rf_sr2      = ir_q[2:0];
  assign bus.rf_dr       = ir_q[11:9];
  assign bus.alu_ir      = ir_q[5:0];
  assign bus.alu_ra      = op_a_q;
  assign bus.alu_rb      = op_b_q;
  assign bus.alu_control = in_write ? fn_q : ALU_PASS;
  assign bus.rf_wr_data  = in_write ? bus.alu_out : '0;

  lc3_cc_reg #(
    .DATA_W (DATA_W)
  ) u_cc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (in_write),
    .data    (bus.alu_out),
    .nzp     (bus.nzp)
  );

endmodule
`default_nettype wire

// File: tb/tb_lc3_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_lc3_alu_sequencer                                              |
// | Self-checking bench: register file and ALU models around the sequencer,    |
// | directed and random operate instructions against an ISA-level model.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_lc3_alu_sequencer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  lc3_alu_sequencer_if #(.DATA_W(16)) bus ();

  lc3_alu_sequencer #(
    .DATA_W     (16),
    .STRICT_NOT (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- environment: register file + ALU ----------------------
  logic [15:0] rf_mem [8];
  logic        pre_en  = 1'b0;
  logic [2:0]  pre_idx = '0;
  logic [15:0] pre_val = '0;

  always @(posedge clk) begin
    if (bus.rf_rd_en) begin
      bus.rf_ra <= rf_mem[bus.rf_sr1];
      bus.rf_rb <= rf_mem[bus.rf_sr2];
    end
    if (bus.rf_wr_en) rf_mem[bus.rf_dr] <= bus.rf_wr_data;
    if (pre_en)       rf_mem[pre_idx]   <= pre_val;
  end

  logic [15:0] alu_b_sel;
  always_comb begin
    alu_b_sel = bus.alu_ir[5] ? {{11{bus.alu_ir[4]}}, bus.alu_ir[4:0]} : bus.alu_rb;
    case (bus.alu_control)
      2'b01:   bus.alu_out = bus.alu_ra + alu_b_sel;
      2'b10:   bus.alu_out = bus.alu_ra & alu_b_sel;
      2'b11:   bus.alu_out = ~bus.alu_ra;
      default: bus.alu_out = bus.alu_ra;
    endcase
  end

  // ---------------- ISA-level reference model ------------------------------
  logic [15:0] model_regs [8];
  logic [2:0]  model_nzp = 3'b010;

  function automatic void ref_exec(input logic [15:0] w, output bit legal,
                                   output logic [2:0] dr, output logic [15:0] res);
    logic [15:0] a;
    logic [15:0] b;
    a     = model_regs[w[8:6]];
    b     = w[5] ? {{11{w[4]}}, w[4:0]} : model_regs[w[2:0]];
    dr    = w[11:9];
    legal = 1'b1;
    res   = '0;
    case (w[15:12])
      4'h1:    res = a + b;
      4'h5:    res = a & b;
      4'h9:    begin res = ~a; legal = (w[5:0] == 6'h3F); end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [15:0] r);
    if (r[15])      return 3'b100;
    else if (r == 0) return 3'b010;
    else            return 3'b001;
  endfunction

  // ---------------- stimulus helpers (no comparisons inside) ---------------
  task automatic set_reg(input int idx, input logic [15:0] v);
    pre_en  = 1'b1;
    pre_idx = idx[2:0];
    pre_val = v;
    @(posedge clk); #1;
    pre_en  = 1'b0;
    model_regs[idx] = v;
  endtask

  // Offers one instruction from IDLE and observes six following cycles.
  task automatic issue_obs(input logic [15:0] w, output int lat, output int rd_cnt,
                           output int wr_cnt, output int ill_k, output int ill_cnt,
                           output int strobe_bad, output logic ready1,
                           output logic [2:0] dr, output logic [15:0] data);
    lat = 0; rd_cnt = 0; wr_cnt = 0; ill_k = 0; ill_cnt = 0; strobe_bad = 0;
    ready1 = 1'b0; dr = '0; data = '0;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) ready1 = bus.instr_ready;
      if (bus.rf_rd_en) rd_cnt++;
      if (bus.illegal) begin ill_cnt++; if (ill_k == 0) ill_k = k; end
      if (bus.done !== bus.rf_wr_en) strobe_bad++;
      if (!bus.rf_wr_en && bus.alu_control !== 2'b00) strobe_bad++;
      if (bus.rf_wr_en) begin
        wr_cnt++;
        if (lat == 0) begin lat = k; dr = bus.rf_dr; data = bus.rf_wr_data; end
      end
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    int wr_seen;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    reset_n         = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b expected 010", bus.nzp); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready); end
    checks++; if ({bus.rf_rd_en, bus.rf_wr_en, bus.done, bus.illegal} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.rf_rd_en, bus.rf_wr_en, bus.done, bus.illegal}); end
    checks++; if ({bus.alu_control, bus.rf_sr1, bus.rf_sr2, bus.rf_dr, bus.alu_ir} !== 17'd0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", {bus.alu_control, bus.rf_sr1, bus.rf_sr2, bus.rf_dr, bus.alu_ir}); end
    checks++; if ({bus.alu_ra, bus.alu_rb, bus.rf_wr_data} !== 48'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.alu_ra, bus.alu_rb, bus.rf_wr_data}); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1 || bus.nzp !== 3'b010) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b nzp=%b expected ready=1 nzp=010", bus.instr_ready, bus.nzp); end

    for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));
    set_reg(3, 16'h0005);
    set_reg(2, 16'hFFF0);
    // Abort an ADD while it is in READ.
    bus.instr       = 16'h16C2;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_rd_en !== 1'b1) begin errors++; $display("FAIL abort_in_read: got rf_rd_en=%b expected 1", bus.rf_rd_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rf_rd_en !== 1'b0 || bus.instr_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got rd_en=%b ready=%b expected 0 1", bus.rf_rd_en, bus.instr_ready); end
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rf_wr_en || bus.done) wr_seen++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rf_wr_en || bus.done) wr_seen++;
    end
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL abort_no_write: got %0d write cycles expected 0", wr_seen); end
    checks++; if (bus.instr_ready !== 1'b1 || bus.nzp !== 3'b010) begin
      errors++; $display("FAIL abort_resume: got ready=%b nzp=%b expected 1 010", bus.instr_ready, bus.nzp); end
    checks++; if (rf_mem[3] !== model_regs[3]) begin
      errors++; $display("FAIL abort_rf_intact: got R3=%h expected %h", rf_mem[3], model_regs[3]); end
    model_nzp = 3'b010;
  endtask

  typedef struct packed {
    logic [15:0] w;
    logic [2:0]  ia;
    logic [15:0] va;
    logic [2:0]  ib;
    logic [15:0] vb;
    logic [2:0]  dr;
    logic [15:0] data;
    logic [2:0]  nzp;
  } dir_t;

  task automatic test_operate();
    dir_t tbl [4];
    int lat, rd, wr, ik, ic, sb;
    logic rdy;
    logic [2:0] dr;
    logic [15:0] data;
    tbl[0] = '{16'h16C2, 3'd3, 16'h0005, 3'd2, 16'hFFF0, 3'd3, 16'hFFF5, 3'b100};
    tbl[1] = '{16'h103B, 3'd0, 16'h0005, 3'd3, 16'h7777, 3'd0, 16'h0000, 3'b010};
    tbl[2] = '{16'h526F, 3'd1, 16'h1234, 3'd7, 16'hFFFF, 3'd1, 16'h0004, 3'b001};
    tbl[3] = '{16'h953F, 3'd4, 16'h00FF, 3'd7, 16'h5A5A, 3'd2, 16'hFF00, 3'b100};
    for (int t = 0; t < 4; t++) begin
      set_reg(tbl[t].ia, tbl[t].va);
      set_reg(tbl[t].ib, tbl[t].vb);
      issue_obs(tbl[t].w, lat, rd, wr, ik, ic, sb, rdy, dr, data);
      checks++; if (lat !== 3 || wr !== 1 || rd !== 1) begin
        errors++; $display("FAIL op%0d_timing: got lat=%0d wr=%0d rd=%0d expected 3 1 1", t, lat, wr, rd); end
      checks++; if (dr !== tbl[t].dr || data !== tbl[t].data) begin
        errors++; $display("FAIL op%0d_result: got R%0d=%h expected R%0d=%h", t, dr, data, tbl[t].dr, tbl[t].data); end
      checks++; if (bus.nzp !== tbl[t].nzp) begin
        errors++; $display("FAIL op%0d_nzp: got %b expected %b", t, bus.nzp, tbl[t].nzp); end
      checks++; if (sb !== 0 || ic !== 0) begin
        errors++; $display("FAIL op%0d_strobes: got bad=%0d illegal=%0d expected 0 0", t, sb, ic); end
      model_regs[tbl[t].dr] = tbl[t].data;
      model_nzp = tbl[t].nzp;
    end
  endtask

  task automatic test_not_strict();
    int lat, rd, wr, ik, ic, sb;
    logic rdy;
    logic [2:0] dr;
    logic [15:0] data;
    issue_obs(16'h953E, lat, rd, wr, ik, ic, sb, rdy, dr, data);
    checks++; if (rd !== 0 || wr !== 0) begin
      errors++; $display("FAIL not_strict_access: got rd=%0d wr=%0d expected 0 0", rd, wr); end
    checks++; if (ic !== 1 || ik !== 1) begin
      errors++; $display("FAIL not_strict_illegal: got count=%0d cycle=%0d expected 1 1", ic, ik); end
    checks++; if (bus.nzp !== model_nzp) begin
      errors++; $display("FAIL not_strict_nzp: got %b expected %b", bus.nzp, model_nzp); end
  endtask

  task automatic test_illegal_opcode();
    int lat, rd, wr, ik, ic, sb;
    logic rdy;
    logic [2:0] dr;
    logic [15:0] data;
    issue_obs(16'h0402, lat, rd, wr, ik, ic, sb, rdy, dr, data);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL br_ready: got %b expected 1", rdy); end
    checks++; if (ic !== 1 || ik !== 1) begin
      errors++; $display("FAIL br_illegal: got count=%0d cycle=%0d expected 1 1", ic, ik); end
    checks++; if (rd !== 0 || wr !== 0 || bus.nzp !== model_nzp) begin
      errors++; $display("FAIL br_side_effect: got rd=%0d wr=%0d nzp=%b expected 0 0 %b", rd, wr, bus.nzp, model_nzp); end
  endtask

  task automatic test_random();
    int lat, rd, wr, ik, ic, sb;
    logic rdy;
    logic [2:0] dr, edr;
    logic [15:0] data, eres, w;
    bit legal;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) set_reg($urandom_range(0, 7), 16'($urandom));
      w = 16'($urandom);
      case ($urandom_range(0, 4))
        0: w[15:12] = 4'h1;
        1: w[15:12] = 4'h5;
        2: begin w[15:12] = 4'h9; if ($urandom_range(0, 2) != 0) w[5:0] = 6'h3F; end
        3: w[15:12] = 4'h1;
        default: begin
          w[15:12] = 4'($urandom);
          if (w[15:12] == 4'h1 || w[15:12] == 4'h5 || w[15:12] == 4'h9) w[15:12] = 4'hE;
        end
      endcase
      ref_exec(w, legal, edr, eres);
      issue_obs(w, lat, rd, wr, ik, ic, sb, rdy, dr, data);
      if (legal) begin
        checks++; if (lat !== 3 || wr !== 1 || dr !== edr || data !== eres || bus.nzp !== ref_nzp(eres) || sb !== 0) begin
          errors++; $display("FAIL rand%0d_%h: got lat=%0d wr=%0d R%0d=%h nzp=%b bad=%0d expected 3 1 R%0d=%h nzp=%b 0",
                             n, w, lat, wr, dr, data, bus.nzp, sb, edr, eres, ref_nzp(eres)); end
        model_regs[edr] = eres;
        model_nzp = ref_nzp(eres);
      end else begin
        checks++; if (wr !== 0 || rd !== 0 || ic !== 1 || ik !== 1 || bus.nzp !== model_nzp) begin
          errors++; $display("FAIL rand%0d_illegal_%h: got wr=%0d rd=%0d ill=%0d@%0d nzp=%b expected 0 0 1@1 %b",
                             n, w, wr, rd, ic, ik, bus.nzp, model_nzp); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [3];
    logic [2:0]  edr [3];
    logic [15:0] eres [3];
    int acc_cyc [3];
    int acc, wr, run, runs, bad_runs, bad_wr;
    bit legal;
    q[0] = 16'h1242; q[1] = 16'h127F; q[2] = 16'h1841;
    set_reg(1, 16'h0010);
    set_reg(2, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      ref_exec(q[i], legal, edr[i], eres[i]);
      model_regs[edr[i]] = eres[i];
    end
    acc = 0; wr = 0; run = 0; runs = 0; bad_runs = 0; bad_wr = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    bus.instr = q[0];
    bus.instr_valid = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (!bus.instr_ready) run++;
      else if (run > 0) begin runs++; if (run != 3) bad_runs++; run = 0; end
      if (bus.rf_wr_en) begin
        if (wr < 3 && (bus.rf_dr !== edr[wr] || bus.rf_wr_data !== eres[wr])) bad_wr++;
        wr++;
      end
      if (bus.instr_ready && bus.instr_valid && acc < 3) begin
        acc_cyc[acc] = cyc;
        acc++;
        @(posedge clk); #1;
        if (acc < 3) bus.instr = q[acc];
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    checks++; if (acc !== 3 || wr !== 3) begin
      errors++; $display("FAIL b2b_counts: got accepts=%0d writes=%0d expected 3 3", acc, wr); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d %0d expected 4 4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
    checks++; if (runs !== 3 || bad_runs !== 0) begin
      errors++; $display("FAIL b2b_ready_low: got runs=%0d bad=%0d expected 3 0", runs, bad_runs); end
    checks++; if (bad_wr !== 0) begin
      errors++; $display("FAIL b2b_write_order: got %0d wrong writes expected 0", bad_wr); end
    checks++; if (rf_mem[1] !== 16'h0012 || rf_mem[4] !== 16'h0024) begin
      errors++; $display("FAIL b2b_final_regs: got R1=%h R4=%h expected 0012 0024", rf_mem[1], rf_mem[4]); end
    model_nzp = ref_nzp(eres[2]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_operate();
    test_not_strict();
    test_illegal_opcode();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
